// File: rtl/controlador_contador_if.sv
// Board-side signal bundle for the up/down counter controller: raw buttons,
// level controls and preset switches in, count and status out.
interface controlador_contador_if;
   logic       btn_start;
   logic       btn_pause;
   logic       dir_up;
   logic       load_en;
   logic [3:0] load_val;
   logic [3:0] value;
   logic [1:0] state;
   logic       tick;
   logic       wrap;

   modport master (
      output btn_start, btn_pause, dir_up, load_en, load_val,
      input  value, state, tick, wrap
   );

   modport slave (
      input  btn_start, btn_pause, dir_up, load_en, load_val,
      output value, state, tick, wrap
   );
endinterface

// File: rtl/controlador_contador.sv
// Prescaled 4-bit up/down counter with start/pause buttons and preset load.
//   state | meaning
//   IDLE  | stopped, load allowed, waiting for start
//   RUN   | prescaler advancing, one count step per PRESCALE cycles
//   PAUSE | stopped with prescaler held, load allowed, start/pause resumes
module controlador_contador #(
   parameter int PRESCALE = 50000000
) (
   input logic                  clk,
   input logic                  rst_n,
   controlador_contador_if.slave bus
);
   localparam int PW = $clog2(PRESCALE);
   localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10
   } st_t;

   st_t           st;
   logic [1:0]    start_sy;
   logic [1:0]    pause_sy;
   logic [1:0]    dir_sy;
   logic [1:0]    load_sy;
   logic          start_prev;
   logic          pause_prev;
   logic [1:0]    fill;
   logic [PW-1:0] pre;
   logic [3:0]    cnt;
   logic          tick_r;
   logic          wrap_r;
   logic          start_ev;
   logic          pause_ev;

   assign start_ev = start_sy[1] & ~start_prev;
   assign pause_ev = pause_sy[1] & ~pause_prev;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st         <= IDLE;
         start_sy   <= '0;
         pause_sy   <= '0;
         dir_sy     <= '0;
         load_sy    <= '0;
         // Edge history starts "high" so a button held through reset is not an event.
         start_prev <= 1'b1;
         pause_prev <= 1'b1;
         fill       <= '0;
         pre        <= '0;
         cnt        <= '0;
         tick_r     <= 1'b0;
         wrap_r     <= 1'b0;
      end else begin
         start_sy <= {start_sy[0], bus.btn_start};
         pause_sy <= {pause_sy[0], bus.btn_pause};
         dir_sy   <= {dir_sy[0], bus.dir_up};
         load_sy  <= {load_sy[0], bus.load_en};
         fill     <= {fill[0], 1'b1};
         // Only track real history once the synchronizers hold post-reset samples.
         start_prev <= fill[1] ? start_sy[1] : 1'b1;
         pause_prev <= fill[1] ? pause_sy[1] : 1'b1;
         tick_r   <= 1'b0;
         wrap_r   <= 1'b0;

         case (st)
            IDLE: begin
               if (load_sy[1]) cnt <= bus.load_val;
               if (start_ev) begin
                  st  <= RUN;
                  pre <= '0;
               end
            end
            RUN: begin
               if (pause_ev) begin
                  st <= PAUSE;
               end else if (pre == PMAX) begin
                  pre    <= '0;
                  tick_r <= 1'b1;
                  if (dir_sy[1]) begin
                     cnt    <= cnt + 4'd1;
                     wrap_r <= (cnt == 4'hF);
                  end else begin
                     cnt    <= cnt - 4'd1;
                     wrap_r <= (cnt == 4'h0);
                  end
               end else begin
                  pre <= pre + PW'(1);
               end
            end
            PAUSE: begin
               if (load_sy[1]) cnt <= bus.load_val;
               if (start_ev || pause_ev) st <= RUN;
            end
            default: st <= IDLE;
         endcase
      end
   end

   assign bus.value = cnt;
   assign bus.state = st;
   assign bus.tick  = tick_r;
   assign bus.wrap  = wrap_r;
endmodule

// File: tb/tb_controlador_contador.sv
// Bench for controlador_contador at PRESCALE = 4: scenario tasks compare the
// outputs against counts derived from elapsed run cycles and the preset value.
module tb_controlador_contador;
   localparam int P = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   controlador_contador_if bus();

   controlador_contador #(.PRESCALE(P)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.btn_start = 1'b0;
      bus.btn_pause = 1'b0;
      bus.dir_up    = 1'b1;
      bus.load_en   = 1'b0;
      bus.load_val  = 4'd0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;
      repeat (3) cyc();
   endtask

   task automatic do_load(input logic [3:0] lv);
      bus.load_val = lv;
      bus.load_en  = 1'b1;
      repeat (3) cyc();
      bus.load_en  = 1'b0;
      repeat (3) cyc();
   endtask

   // Count reached after k steps from base, wrapping modulo 16.
   function automatic logic [3:0] model_val(input logic [3:0] base, input logic up, input int k);
      int v;
      v = up ? (int'(base) + k) : (int'(base) - k);
      v = ((v % 16) + 16) % 16;
      return 4'(v);
   endfunction

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.btn_start = 1'($urandom);
         bus.btn_pause = 1'($urandom);
         bus.load_en   = 1'($urandom);
         bus.load_val  = 4'($urandom);
         cyc();
         vectors++;
         if (bus.value !== 4'd0 || bus.state !== 2'b00 || bus.tick !== 1'b0 || bus.wrap !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got v=%0d s=%0d t=%0b w=%0b want 0 0 0 0", bus.value, bus.state, bus.tick, bus.wrap);
         end
      end
      idle_inputs();
      rst_n = 1'b1;
      repeat (4) cyc();
      vectors++;
      if (bus.value !== 4'd0 || bus.state !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_release got v=%0d s=%0d want 0 0", bus.value, bus.state);
      end
   endtask

   task automatic test_count_sequence();
      logic [3:0] tbl_lv [3] = '{4'd0, 4'd14, 4'd1};
      logic       tbl_up [3] = '{1'b1, 1'b1, 1'b0};
      int         tbl_n  [3] = '{2, 2, 3};
      for (int it = 0; it < 8; it++) begin
         logic [3:0] lv;
         logic       up;
         int         n;
         if (it < 3) begin
            lv = tbl_lv[it]; up = tbl_up[it]; n = tbl_n[it];
         end else begin
            lv = 4'($urandom); up = 1'($urandom); n = $urandom_range(1, 20);
         end
         idle_inputs();
         do_reset();
         bus.dir_up = up;
         do_load(lv);
         vectors++;
         if (bus.value !== lv || bus.state !== 2'b00 || bus.tick !== 1'b0) begin
            miscompares++;
            $display("FAIL load_idle got v=%0d s=%0d t=%0b want %0d 0 0", bus.value, bus.state, bus.tick, lv);
         end
         bus.btn_start = 1'b1;
         cyc();
         cyc();
         vectors++;
         if (bus.state !== 2'b00) begin
            miscompares++;
            $display("FAIL start_latency_early got s=%0d want 0", bus.state);
         end
         cyc();
         vectors++;
         if (bus.state !== 2'b01 || bus.value !== lv) begin
            miscompares++;
            $display("FAIL start_run got s=%0d v=%0d want 1 %0d", bus.state, bus.value, lv);
         end
         for (int c = 1; c <= n * P; c++) begin
            logic [3:0] ev;
            logic       et, ew;
            if (c == 3) bus.btn_start = 1'b0;
            cyc();
            ev = model_val(lv, up, c / P);
            et = (c % P == 0);
            ew = et && (up ? (ev == 4'd0) : (ev == 4'd15));
            vectors++;
            if (bus.value !== ev || bus.tick !== et || bus.wrap !== ew || bus.state !== 2'b01) begin
               miscompares++;
               $display("FAIL count_step c=%0d got v=%0d t=%0b w=%0b s=%0d want %0d %0b %0b 1", c, bus.value, bus.tick, bus.wrap, bus.state, ev, et, ew);
            end
         end
      end
   endtask

   task automatic test_pause();
      for (int it = 0; it < 4; it++) begin
         int adv, w, rem;
         logic [3:0] frozen;
         logic by_start;
         w = (it == 0) ? 0 : $urandom_range(0, 9);
         by_start = (it % 2 == 1);
         idle_inputs();
         do_reset();
         bus.btn_start = 1'b1;
         repeat (3) cyc();
         bus.btn_start = 1'b0;
         vectors++;
         if (bus.state !== 2'b01) begin
            miscompares++;
            $display("FAIL pause_setup got s=%0d want 1", bus.state);
         end
         adv = 0;
         for (int i = 0; i < w + 2; i++) begin
            if (i == w) bus.btn_pause = 1'b1;
            cyc();
            adv++;
            vectors++;
            if (bus.tick !== (adv % P == 0) || bus.value !== 4'(adv / P)) begin
               miscompares++;
               $display("FAIL pause_prerun adv=%0d got t=%0b v=%0d want %0b %0d", adv, bus.tick, bus.value, (adv % P == 0), adv / P);
            end
         end
         cyc();
         bus.btn_pause = 1'b0;
         frozen = 4'(adv / P);
         vectors++;
         if (bus.state !== 2'b10 || bus.tick !== 1'b0 || bus.value !== frozen) begin
            miscompares++;
            $display("FAIL pause_enter got s=%0d t=%0b v=%0d want 2 0 %0d", bus.state, bus.tick, bus.value, frozen);
         end
         for (int i = 0; i < 20; i++) begin
            cyc();
            vectors++;
            if (bus.state !== 2'b10 || bus.tick !== 1'b0 || bus.wrap !== 1'b0 || bus.value !== frozen) begin
               miscompares++;
               $display("FAIL pause_hold i=%0d got s=%0d t=%0b v=%0d want 2 0 %0d", i, bus.state, bus.tick, bus.value, frozen);
            end
         end
         if (by_start) bus.btn_start = 1'b1; else bus.btn_pause = 1'b1;
         cyc();
         cyc();
         cyc();
         bus.btn_start = 1'b0;
         bus.btn_pause = 1'b0;
         vectors++;
         if (bus.state !== 2'b01 || bus.tick !== 1'b0 || bus.value !== frozen) begin
            miscompares++;
            $display("FAIL pause_resume got s=%0d t=%0b v=%0d want 1 0 %0d", bus.state, bus.tick, bus.value, frozen);
         end
         rem = P - (adv % P);
         for (int j = 1; j <= rem; j++) begin
            cyc();
            vectors++;
            if (bus.tick !== (j == rem) || bus.value !== ((j == rem) ? 4'(frozen + 4'd1) : frozen)) begin
               miscompares++;
               $display("FAIL resume_tick j=%0d rem=%0d got t=%0b v=%0d", j, rem, bus.tick, bus.value);
            end
         end
      end
   endtask

   task automatic test_simultaneous();
      int adv;
      idle_inputs();
      do_reset();
      bus.btn_pause = 1'b1;
      repeat (3) cyc();
      bus.btn_pause = 1'b0;
      vectors++;
      if (bus.state !== 2'b00) begin
         miscompares++;
         $display("FAIL idle_pause_ignored got s=%0d want 0", bus.state);
      end
      repeat (3) cyc();
      bus.btn_start = 1'b1; bus.btn_pause = 1'b1;
      repeat (3) cyc();
      bus.btn_start = 1'b0; bus.btn_pause = 1'b0;
      vectors++;
      if (bus.state !== 2'b01) begin
         miscompares++;
         $display("FAIL both_idle got s=%0d want 1", bus.state);
      end
      cyc();
      adv = 1;
      bus.btn_start = 1'b1; bus.btn_pause = 1'b1;
      cyc(); cyc();
      adv += 2;
      cyc();
      bus.btn_start = 1'b0; bus.btn_pause = 1'b0;
      vectors++;
      if (bus.state !== 2'b10 || bus.value !== 4'd0) begin
         miscompares++;
         $display("FAIL both_run got s=%0d v=%0d want 2 0", bus.state, bus.value);
      end
      repeat (3) cyc();
      bus.btn_start = 1'b1; bus.btn_pause = 1'b1;
      repeat (3) cyc();
      bus.btn_start = 1'b0; bus.btn_pause = 1'b0;
      vectors++;
      if (bus.state !== 2'b01) begin
         miscompares++;
         $display("FAIL both_pause got s=%0d want 1", bus.state);
      end
      bus.load_val = 4'd7;
      bus.load_en  = 1'b1;
      for (int j = 0; j < 12; j++) begin
         cyc();
         adv++;
         vectors++;
         if (bus.state !== 2'b01 || bus.tick !== (adv % P == 0) || bus.value !== 4'(adv / P)) begin
            miscompares++;
            $display("FAIL run_load_ignored adv=%0d got s=%0d t=%0b v=%0d want 1 %0b %0d", adv, bus.state, bus.tick, bus.value, (adv % P == 0), adv / P);
         end
      end
      bus.load_en = 1'b0;
      // Load and start together from IDLE.
      do_reset();
      bus.load_val = 4'd5;
      bus.load_en = 1'b1; bus.btn_start = 1'b1;
      repeat (3) cyc();
      bus.load_en = 1'b0; bus.btn_start = 1'b0;
      vectors++;
      if (bus.state !== 2'b01 || bus.value !== 4'd5) begin
         miscompares++;
         $display("FAIL load_start got s=%0d v=%0d want 1 5", bus.state, bus.value);
      end
      for (int c = 1; c <= P; c++) begin
         cyc();
         vectors++;
         if (bus.tick !== (c == P) || bus.value !== ((c == P) ? 4'd6 : 4'd5)) begin
            miscompares++;
            $display("FAIL load_start_step c=%0d got t=%0b v=%0d", c, bus.tick, bus.value);
         end
      end
   endtask

   task automatic test_reset_midcount();
      idle_inputs();
      do_reset();
      do_load(4'd9);
      bus.btn_start = 1'b1;
      repeat (3) cyc();
      vectors++;
      if (bus.state !== 2'b01 || bus.value !== 4'd9) begin
         miscompares++;
         $display("FAIL mid_setup got s=%0d v=%0d want 1 9", bus.state, bus.value);
      end
      repeat (5) cyc();
      rst_n = 1'b0;
      bus.btn_pause = 1'b1;
      bus.load_en = 1'b1;
      bus.load_val = 4'd3;
      cyc();
      rst_n = 1'b1;
      bus.btn_pause = 1'b0;
      bus.load_en = 1'b0;
      vectors++;
      if (bus.value !== 4'd0 || bus.state !== 2'b00 || bus.tick !== 1'b0 || bus.wrap !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset got v=%0d s=%0d t=%0b w=%0b want 0 0 0 0", bus.value, bus.state, bus.tick, bus.wrap);
      end
      for (int i = 0; i < 10; i++) begin
         cyc();
         vectors++;
         if (bus.state !== 2'b00 || bus.value !== 4'd0 || bus.tick !== 1'b0) begin
            miscompares++;
            $display("FAIL held_start i=%0d got s=%0d v=%0d t=%0b want 0 0 0", i, bus.state, bus.value, bus.tick);
         end
      end
      bus.btn_start = 1'b0;
      repeat (3) cyc();
      bus.btn_start = 1'b1;
      repeat (3) cyc();
      bus.btn_start = 1'b0;
      vectors++;
      if (bus.state !== 2'b01) begin
         miscompares++;
         $display("FAIL repress_start got s=%0d want 1", bus.state);
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_count_sequence();
      test_pause();
      test_simultaneous();
      test_reset_midcount();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/controlador_contador.md
CONTROLADOR_CONTADOR -- requirements
Module: controlador_contador

Interface
REQ-001 Parameter: PRESCALE, default 50000000, clk cycles per count step; legal range >= 2.
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 btn_start  input  1  raw pushbutton, active-high, asynchronous to clk.
REQ-005 btn_pause  input  1  raw pushbutton, active-high, asynchronous to clk.
REQ-006 dir_up  input  1  level: 1 = count up, 0 = count down; asynchronous.
REQ-007 load_en  input  1  level: request to load load_val; asynchronous.
REQ-008 load_val  input  4  preset value from board switches.
REQ-009 value  output  4  registered count; drives the 4-bit input of the two-digit 7-segment decoder.
REQ-010 state  output  2  registered FSM state: 00 IDLE, 01 RUN, 10 PAUSE; 11 never driven.
REQ-011 tick  output  1  registered one-cycle pulse, high in the cycle value takes a new count-step value.
REQ-012 wrap  output  1  registered one-cycle pulse, high with tick when value rolls over (15->0 up, 0->15 down).

Function
REQ-013 btn_start, btn_pause, dir_up and load_en SHALL each pass through a 2-flop synchronizer before any use.
REQ-014 Button events SHALL be rising edges of the synchronized signal; a button held high gives exactly one event.
REQ-015 Event latency: button first sampled high at edge E0 -> resulting state/value change visible after edge E2.
REQ-016 IDLE: start event -> RUN with prescaler = 0; pause event ignored.
REQ-017 RUN: pause event -> PAUSE with prescaler count held; start event ignored.
REQ-018 PAUSE: start or pause event -> RUN; prescaler resumes from the held count.
REQ-019 Simultaneous start and pause events: IDLE -> RUN; RUN -> PAUSE; PAUSE -> RUN (single transition).
REQ-020 Prescaler: ceil(log2(PRESCALE))-bit counter; increments only in RUN; 0..PRESCALE-1; at PRESCALE-1 next edge clears it and performs one count step.
REQ-021 Count step: value <= value+1 mod 16 if synchronized dir_up = 1, else value-1 mod 16; tick = 1 for exactly that cycle.
REQ-022 wrap SHALL be 1 only in a tick cycle where the step rolled over; otherwise 0.
REQ-023 First tick after IDLE->RUN SHALL appear exactly PRESCALE cycles after the state output first shows RUN; subsequent ticks every PRESCALE cycles.
REQ-024 A dir_up change SHALL affect only steps whose tick edge occurs at least 3 edges after the change is first sampled; it never alters value directly.
REQ-025 Synchronized load_en high in IDLE or PAUSE: value <= load_val each cycle while high; tick and wrap stay 0; state unchanged.
REQ-026 load_en in RUN SHALL be ignored.
REQ-027 Load and start event in the same cycle in IDLE: load applies and state -> RUN in that same edge.
REQ-028 tick and wrap SHALL be 0 in IDLE and PAUSE.

Reset
REQ-029 rst_n low at a clk edge, in any state or mid-count: value = 0, state = 00, tick = 0, wrap = 0, prescaler = 0, synchronizer and edge history cleared.
REQ-030 A button held high across reset release SHALL NOT produce an event; it must go low and high again.
REQ-031 Reset SHALL dominate every other input in the same cycle.

Verification (PRESCALE = 4)
REQ-032 Reset; btn_start high 5 cycles from E0 -> state = 01 after E2; value 0->1 with tick = 1 four cycles later; value 2 after 4 more.
REQ-033 IDLE, load_en with load_val = 14, then start, dir_up = 1 -> value 14, 15, 0; wrap = 1 only with the 15->0 tick.
REQ-034 dir_up = 0, load 1, start -> value 1, 0, 15; wrap = 1 with the 0->15 tick; next value 14.
REQ-035 RUN with prescaler = 2: pause -> state 10, value frozen, no tick for 20 cycles; pause again -> RUN, next tick exactly 2 cycles later.
REQ-036 RUN: start and pause pressed together -> PAUSE; load_en with load_val = 7 in RUN -> value unchanged.
REQ-037 RUN at value 9, rst_n low one cycle with btn_start held -> value 0, state 00, tick 0; stays IDLE until btn_start released and re-pressed.
